// File: rtl/ifu_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// ifu_prefetch_pkg
//   Shared constants and types for the instruction fetch unit: the fetch FSM
//   state encoding, the all-zero instruction word, the default reset PC and
//   a helper that forces an address onto a word boundary.
// -----------------------------------------------------------------------------
package ifu_prefetch_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH      = 2'd1,
      FLUSH      = 2'd2
   } ifu_state_e;

   localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// ifu_prefetch_fifo
//   In-order prefetch buffer holding {addr, inst} pairs.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset (pointers/count only)
//     i_push     write i_data at the tail
//     i_pop      drop the head entry (ignored when empty)
//     i_flush    empty the buffer; wins over push and pop in the same cycle
//     i_data     64-bit {addr, inst} to store
//     o_count    number of valid entries (0..FIFO_DEPTH)
//     o_empty    buffer holds no entry
//     o_head     {addr, inst} at the head (undefined contents when empty)
// -----------------------------------------------------------------------------
module ifu_prefetch_fifo #(
   parameter  int FIFO_DEPTH = 4,
   localparam int AW         = $clog2(FIFO_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_flush,
   input  logic [63:0]   i_data,
   output logic [AW:0]   o_count,
   output logic          o_empty,
   output logic [63:0]   o_head
);

   logic [63:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign w_push  = i_push & ~i_flush;
   assign w_pop   = i_pop & ~i_flush & (r_count != '0);
   assign o_count = r_count;
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is data only; validity is carried entirely by the pointers.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

endmodule

// File: rtl/ifu_prefetch.sv
// -----------------------------------------------------------------------------
// ifu_prefetch
//   Instruction fetch unit with an in-order prefetch buffer. Issues sequential
//   word fetches over a req/gnt interface, buffers in-order responses and
//   hands {inst, instaddr} to the decode stage with valid/ready. A redirect
//   retargets fetch and discards every response still in flight.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     redirect_i      flush and restart fetch at redirect_pc_i (bits [1:0] dropped)
//     mem_req_o       fetch request; held with mem_addr_o stable until granted
//     mem_addr_o      word-aligned fetch address
//     mem_gnt_i       request accepted when mem_req_o && mem_gnt_i
//     mem_rvalid_i    in-order read response valid, mem_rdata_i carries the word
//     inst_valid_o    buffer head valid (forced low during redirect)
//     inst_o          head instruction, zero when buffer empty
//     instaddr_o      head address, zero when buffer empty
//     inst_ready_i    consumer accepts head when inst_valid_o && inst_ready_i
// -----------------------------------------------------------------------------
module ifu_prefetch
   import ifu_prefetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] instaddr_o,
   input  logic        inst_ready_i
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   ifu_state_e    r_state;
   ifu_state_e    w_state_nxt;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_discard;
   logic [CW-1:0] w_out_nxt;
   logic [CW-1:0] w_discard_nxt;
   logic [CW-1:0] w_count;
   logic [CW:0]   w_committed;
   logic          w_credit;
   logic          w_empty;
   logic [63:0]   w_head;
   logic          w_grant;
   logic          w_rsp;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_redirect_pc;

   assign w_redirect_pc = word_align(redirect_pc_i);

   // Buffered words plus words still owed by memory must fit in the buffer,
   // so a push can never find it full.
   assign w_committed = {1'b0, w_count} + {1'b0, r_outstanding};
   assign w_credit    = (w_committed < (CW+1)'(FIFO_DEPTH));

   // A response with nothing outstanding is a protocol error and is ignored.
   assign w_rsp   = mem_rvalid_i && (r_outstanding != '0);
   assign w_grant = mem_req_o && mem_gnt_i;
   assign w_push  = w_rsp && (r_discard == '0) && !redirect_i;
   assign w_pop   = inst_valid_o && inst_ready_i;

   always_comb begin
      w_out_nxt = r_outstanding;
      if (w_grant && !w_rsp)
         w_out_nxt = r_outstanding + CW'(1);
      else if (!w_grant && w_rsp)
         w_out_nxt = r_outstanding - CW'(1);

      // On redirect every request still owed (including one granted this
      // cycle) becomes stale.
      w_discard_nxt = r_discard;
      if (redirect_i)
         w_discard_nxt = w_out_nxt;
      else if (w_rsp && (r_discard != '0))
         w_discard_nxt = r_discard - CW'(1);
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= FETCH_IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FETCH_IDLE: w_state_nxt = FETCH;
         FETCH:      w_state_nxt = FETCH;
         FLUSH:      if (w_discard_nxt == '0) w_state_nxt = FETCH;
         default:    w_state_nxt = FETCH_IDLE;
      endcase
      if (redirect_i)
         w_state_nxt = (w_out_nxt != '0) ? FLUSH : FETCH;
   end

   // FSM: outputs
   always_comb begin
      mem_req_o    = (r_state == FETCH) && !redirect_i && w_credit;
      mem_addr_o   = r_fetch_pc;
      inst_valid_o = !w_empty && !redirect_i;
      inst_o       = w_empty ? ZERO_WORD : w_head[31:0];
      instaddr_o   = w_empty ? ZERO_WORD : w_head[63:32];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_outstanding <= w_out_nxt;
         r_discard     <= w_discard_nxt;
         if (redirect_i) begin
            r_fetch_pc <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
         end else begin
            if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
            // Responses arrive in order, so the address of each kept word is
            // simply the next one in sequence from the last retarget.
            if (w_push)  r_resp_pc  <= r_resp_pc + 32'd4;
         end
      end
   end

   ifu_prefetch_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_i),
      .i_data  ({r_resp_pc, mem_rdata_i}),
      .o_count (w_count),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   rvalid_needs_outstanding: assert property (
      @(posedge clk) disable iff (rst) !(mem_rvalid_i && (r_outstanding == '0))
   );

endmodule
